lsu: RTL and testbench
======================

// Module: lsu
// PURPOSE
//  Load/store unit directly downstream of the ALU: consumes the ALU result as the effective address.
//  Issues one word-aligned data-memory access per instruction and returns write-back data to the MEM/WB stage.
//  Generates byte strobes and replicated store data; extracts and sign/zero-extends load data.
//  Single outstanding access; valid/ready on both pipeline sides, req/gnt/rvalid on the memory side.
// PARAMETERS
//  MEM_TIMEOUT  255  cycles allowed in REQ+WAIT before bus error (0 = timeout disabled)
// PORTS
//  clk          in   1   sole clock, rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  in_valid     in   1   execute stage presents a memory op
//  in_ready     out  1   LSU can accept (high only in IDLE)
//  in_is_store  in   1   1 = store, 0 = load
//  in_funct3    in   3   RV32I width/sign field
//  in_addr      in   32  effective address (ALU result)
//  in_wdata     in   32  rs2 value for stores
//  in_rd        in   5   destination register for loads
//  mem_req      out  1   memory request, held until mem_gnt
//  mem_gnt      in   1   memory accepted request this cycle
//  mem_we       out  1   1 = write
//  mem_addr     out  32  {addr[31:2],2'b00}
//  mem_wstrb    out  4   byte-enable strobes
//  mem_wdata    out  32  lane-replicated store data
//  mem_rvalid   in   1   response (loads and stores), >=1 cycle after gnt
//  mem_rdata    in   32  raw read word
//  out_valid    out  1   result available, held until out_ready
//  out_ready    in   1   downstream accepts
//  out_we       out  1   1 = register write-back (loads only, never on error)
//  out_rd       out  5   destination register
//  out_data     out  32  extended load data (0 for stores/errors)
//  out_err      out  1   illegal funct3, timeout, or misalignment trap
// BEHAVIOUR
//  Reset: state IDLE; every output 0 except in_ready=1 once rst_n deasserts. Counter cleared.
//  FSM IDLE->REQ->WAIT->DONE->IDLE:
//   IDLE: in_ready=1; on in_valid: capture op, addr, wdata, rd. Illegal funct3 (load 011/110/111, store >=011)
//         or misaligned-with-trap -> DONE with out_err=1, no memory access; else -> REQ.
//   REQ:  mem_req=1, mem_* stable until mem_gnt; on gnt -> WAIT.
//   WAIT: on mem_rvalid -> DONE; load data captured from mem_rdata that cycle.
//   DONE: out_valid=1; outputs stable until out_ready, then IDLE. No new accept in DONE.
//  Minimum latency: accept c0, gnt c1, rvalid c2, out_valid c3.
//  Timeout: counter increments each cycle in REQ/WAIT; reaching MEM_TIMEOUT -> DONE, out_err=1, out_we=0,
//   mem_req dropped. Late rvalid or rvalid outside WAIT ignored.
//  Strobes: SB 4'b0001<<a[1:0]; SH 4'b0011<<{a[1],1'b0}; SW 4'b1111. Store data: byte x4, half x2, word as-is.
//  Loads: select lane by a[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW as-is.
//  Reset mid-operation: immediate return to IDLE, mem_req drops, outstanding response discarded.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined: half with a[0]=1 or word with a[1:0]!=0 -> no access, out_err=1, out_we=0.
//  Undefined: misaligned low bits ignored (half aligned to a[1], word to a[1:0]=0), access proceeds, no error.
// STRUCTURE
//  Shared package/header: funct3 constants (F3_B,F3_H,F3_W,F3_BU,F3_HU), FSM state encodings.
//  Sub-module lsu_align (combinational): strobe/store-data generation and load extract/extend.
//  Top: FSM, capture registers, timeout counter, handshakes.
// TESTING
//  SB addr 0x103, wdata 0xAB -> mem_addr 0x100, wstrb 4'b1000, wdata 0xABABABAB, out_we=0, out_err=0.
//  LB addr 0x102, rdata 0x0080_0000 -> out_data 0xFFFFFF80; LBU same -> 0x00000080; out_we=1.
//  LH addr 0x102, rdata 0x8001_0000 -> out_data 0xFFFF8001; gnt c1, rvalid c2 -> out_valid at c3.
//  mem_gnt withheld, MEM_TIMEOUT=4 -> out_err=1 after 4 cycles, mem_req 0, later rvalid ignored.
//  LW addr 0x101: with LSU_MISALIGN_TRAP_EN -> out_err=1, mem_req never asserted; without -> reads 0x100.
//  rst_n low in WAIT, rvalid next cycle -> IDLE, outputs 0, in_ready=1, no out_valid; out_ready low holds DONE.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - RV32I funct3 width/sign encodings used by loads and stores
//   - FSM state encodings for the LSU control path
//   - helpers that classify an incoming operation before it is accepted
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Stores only have B/H/W; the unsigned encodings exist for loads only.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // funct3[1:0] is the access size: 01 = half, 10 = word.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    return ((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the LSU.
//   funct3    in   3   access width/sign
//   addr_lo   in   2   byte offset within the word
//   wdata     in   32  raw store data (rs2)
//   rdata     in   32  raw read word from memory
//   wstrb     out  4   byte strobes for the addressed lanes
//   wdata_rep out  32  store data replicated across all lanes
//   rdata_ext out  32  selected load lane, sign/zero-extended
// Misaligned offsets are folded down to the natural lane (half -> addr_lo[1],
// word -> lane 0); trapping on them is decided by the top level.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;

  always_comb begin
    wstrb     = 4'b1111;
    wdata_rep = wdata;
    shifted   = rdata;
    case (funct3[1:0])
      2'b00: begin
        wstrb     = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        shifted   = rdata >> {addr_lo, 3'b000};
      end
      2'b01: begin
        wstrb     = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
        shifted   = rdata >> {addr_lo[1], 4'b0000};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (funct3)
      F3_B:    rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   rdata_ext = {24'b0, shifted[7:0]};
      F3_H:    rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   rdata_ext = {16'b0, shifted[15:0]};
      default: rdata_ext = rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: takes the ALU result as effective address, issues one
// word-aligned data-memory access per instruction and returns write-back data.
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   in_valid/in_ready                   execute-side handshake (ready only in IDLE)
//   in_is_store, in_funct3, in_addr,
//   in_wdata, in_rd                     operation captured on accept
//   mem_req/mem_gnt, mem_rvalid         memory request/grant/response
//   mem_we, mem_addr, mem_wstrb,
//   mem_wdata, mem_rdata                memory data path
//   out_valid/out_ready                 write-back handshake, held until accepted
//   out_we, out_rd, out_data, out_err   write-back result
// Parameter MEM_TIMEOUT: cycles allowed in REQ+WAIT before a bus error (0 = off).
// Build option LSU_MISALIGN_TRAP_EN: misaligned half/word accesses trap with
// out_err and never reach memory; otherwise the low address bits are ignored.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_is_store,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_rd,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_we,
  output logic [4:0]  out_rd,
  output logic [31:0] out_data,
  output logic        out_err
);

  localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = (MEM_TIMEOUT == 0) ? '0 : CNT_W'(MEM_TIMEOUT - 1);
  localparam logic TMO_EN = (MEM_TIMEOUT != 0);

  logic [1:0]       state;
  logic             op_store;
  logic [2:0]       op_f3;
  logic [31:0]      op_addr;
  logic [31:0]      op_wdata;
  logic [4:0]       op_rd;
  logic [CNT_W-1:0] cnt;
  logic             res_we;
  logic             res_err;
  logic [31:0]      res_data;

  logic [3:0]  strb;
  logic [31:0] wdata_rep;
  logic [31:0] rdata_ext;
  logic        in_trap;
  logic        in_bad;
  logic        tmo;

  lsu_align u_align (
    .funct3    (op_f3),
    .addr_lo   (op_addr[1:0]),
    .wdata     (op_wdata),
    .rdata     (mem_rdata),
    .wstrb     (strb),
    .wdata_rep (wdata_rep),
    .rdata_ext (rdata_ext)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  assign in_trap = f3_misaligned(in_funct3, in_addr[1:0]);
`else
  assign in_trap = 1'b0;
`endif

  // Illegal or trapping ops are decided on the raw inputs so they can go
  // straight to DONE without ever touching memory.
  assign in_bad = !f3_legal(in_is_store, in_funct3) || in_trap;

  // Fires on the MEM_TIMEOUT-th cycle spent in REQ/WAIT; a response arriving
  // in that same WAIT cycle still wins.
  assign tmo = TMO_EN && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      op_store <= 1'b0;
      op_f3    <= '0;
      op_addr  <= '0;
      op_wdata <= '0;
      op_rd    <= '0;
      cnt      <= '0;
      res_we   <= 1'b0;
      res_err  <= 1'b0;
      res_data <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          op_store <= in_is_store;
          op_f3    <= in_funct3;
          op_addr  <= in_addr;
          op_wdata <= in_wdata;
          op_rd    <= in_rd;
          cnt      <= '0;
          res_we   <= 1'b0;
          res_err  <= in_bad;
          res_data <= '0;
          state    <= in_bad ? S_DONE : S_REQ;
        end
        S_REQ: begin
          if (tmo) begin
            res_err <= 1'b1;
            state   <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
            if (mem_gnt) state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            res_we   <= !op_store;
            res_data <= op_store ? '0 : rdata_ext;
            state    <= S_DONE;
          end else if (tmo) begin
            res_err <= 1'b1;
            state   <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: if (out_ready) state <= S_IDLE;
      endcase
    end
  end

  // Outputs are gated by state so everything idles at zero between ops.
  assign in_ready  = rst_n && (state == S_IDLE);
  assign mem_req   = (state == S_REQ);
  assign mem_we    = mem_req && op_store;
  assign mem_addr  = mem_req ? {op_addr[31:2], 2'b00} : '0;
  assign mem_wstrb = mem_req ? strb : '0;
  assign mem_wdata = mem_we ? wdata_rep : '0;
  assign out_valid = (state == S_DONE);
  assign out_we    = out_valid && res_we;
  assign out_rd    = out_valid ? op_rd : '0;
  assign out_data  = out_valid ? res_data : '0;
  assign out_err   = out_valid && res_err;

endmodule

// File: tb/tb_lsu.sv
// Randomized bench for the load/store unit with an in-bench behavioural model.
module tb_lsu;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_is_store = 1'b0;
  logic [2:0]  in_funct3 = '0;
  logic [31:0] in_addr = '0;
  logic [31:0] in_wdata = '0;
  logic [4:0]  in_rd = '0;
  logic        mem_req;
  logic        mem_gnt = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_we;
  logic [4:0]  out_rd;
  logic [31:0] out_data;
  logic        out_err;

  always #5 clk = ~clk;

  lsu #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_is_store(in_is_store),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_we(out_we), .out_rd(out_rd), .out_data(out_data), .out_err(out_err)
  );

  int tests = 0;
  int fails = 0;

  logic        chk_en = 1'b0;
  logic        exp_vld = 1'b0;
  logic        exp_rdy = 1'b0;
  logic        exp_req = 1'b0;
  logic        exp_mwe = 1'b0;
  logic [31:0] exp_maddr = '0;
  logic [3:0]  exp_strb = '0;
  logic [31:0] exp_mwd = '0;
  logic        exp_owe = 1'b0;
  logic        exp_oerr = 1'b0;
  logic [4:0]  exp_ord = '0;
  logic [31:0] exp_odata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit m_legal(input bit st, input int f3);
    if (st) return f3 <= 2;
    return (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
  endfunction

  function automatic bit m_trap(input int f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
    return ((f3 % 4 == 1) && (a % 2 != 0)) || ((f3 % 4 == 2) && (a % 4 != 0));
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] m_strb(input int f3, input logic [31:0] a);
    if (f3 % 4 == 0) return 4'(32'd1 << (a % 4));
    if (f3 % 4 == 1) return 4'(32'd3 << (((a / 2) % 2) * 2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wrep(input int f3, input logic [31:0] w);
    if (f3 % 4 == 0) return (w % 256) * 32'h0101_0101;
    if (f3 % 4 == 1) return (w % 65536) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] m_load(input int f3, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    case (f3)
      0, 4:    v = rd >> ((a % 4) * 8);
      1, 5:    v = rd >> (((a / 2) % 2) * 16);
      default: v = rd;
    endcase
    case (f3)
      0:       return (v % 256 >= 128) ? (v % 256) + 32'hFFFF_FF00 : v % 256;
      4:       return v % 256;
      1:       return (v % 65536 >= 32768) ? (v % 65536) + 32'hFFFF_0000 : v % 65536;
      5:       return v % 65536;
      default: return v;
    endcase
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", 32'(out_valid), 32'(exp_vld));
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("mem_req", 32'(mem_req), 32'(exp_req));
      if (exp_req) begin
        chk("mem_we", 32'(mem_we), 32'(exp_mwe));
        chk("mem_addr", mem_addr, exp_maddr);
        if (exp_mwe) begin
          chk("mem_wstrb", 32'(mem_wstrb), 32'(exp_strb));
          chk("mem_wdata", mem_wdata, exp_mwd);
        end
      end
      if (exp_vld) begin
        chk("out_we", 32'(out_we), 32'(exp_owe));
        chk("out_rd", 32'(out_rd), 32'(exp_ord));
        chk("out_data", out_data, exp_odata);
        chk("out_err", 32'(out_err), 32'(exp_oerr));
      end
    end
  end

  // Enter just after a rising edge with the DUT idle; leaves it idle again.
  // gd = cycles of withheld grant, rvd = gnt-to-rvalid distance, hold = DONE stall.
  task automatic run_op(input bit st, input int f3, input logic [31:0] a, input logic [31:0] w,
                        input logic [4:0] rd, input int gd, input int rvd,
                        input logic [31:0] rdata, input int hold);
    bit bad;
    bit ok;
    int gc;
    int rc;
    int last;
    bad  = !m_legal(st, f3) || m_trap(f3, a);
    gc   = 1 + gd;
    rc   = gc + rvd;
    ok   = !bad && (rc <= T);
    last = (rc < T) ? rc : T;
    exp_mwe   = st;
    exp_maddr = a - (a % 4);
    exp_strb  = m_strb(f3, a);
    exp_mwd   = m_wrep(f3, w);
    exp_owe   = ok && !st;
    exp_oerr  = !ok;
    exp_ord   = rd;
    exp_odata = (ok && !st) ? m_load(f3, a, rdata) : 32'h0;

    in_valid = 1'b1; in_is_store = st; in_funct3 = 3'(f3);
    in_addr = a; in_wdata = w; in_rd = rd;
    exp_rdy = 1'b1; exp_vld = 1'b0; exp_req = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; in_is_store = 1'($urandom); in_funct3 = 3'($urandom);
    in_addr = $urandom; in_wdata = $urandom; in_rd = 5'($urandom);
    exp_rdy = 1'b0;
    if (!bad) begin
      for (int k = 1; k <= last; k++) begin
        exp_req    = (k <= gc);
        mem_gnt    = (k == gc);
        mem_rvalid = (k == rc);
        mem_rdata  = (k == rc) ? rdata : $urandom;
        @(posedge clk); #1;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
      end
    end
    exp_req = 1'b0; exp_vld = 1'b1;
    for (int h = 0; h < hold; h++) begin
      mem_rvalid = 1'($urandom);
      mem_rdata  = $urandom;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; exp_vld = 1'b0; exp_rdy = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int legal_ld[5];
    bit st;
    int f3;
    legal_ld = '{0, 1, 2, 4, 5};

    // Pin the model to hand-computed values.
    chk("model_lb", m_load(0, 32'h102, 32'h0080_0000), 32'hFFFF_FF80);
    chk("model_lbu", m_load(4, 32'h102, 32'h0080_0000), 32'h0000_0080);
    chk("model_lh", m_load(1, 32'h102, 32'h8001_0000), 32'hFFFF_8001);
    chk("model_sb_strb", 32'(m_strb(0, 32'h103)), 32'h8);
    chk("model_sb_wdata", m_wrep(0, 32'hAB), 32'hABAB_ABAB);

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("rst_release_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk); #1;
    exp_rdy = 1'b1;
    chk_en  = 1'b1;

    // Directed cases.
    run_op(1, 0, 32'h103, 32'h0000_00AB, 5'd5, 0, 1, 32'h0, 0);          // SB
    run_op(0, 0, 32'h102, 32'h0, 5'd7, 0, 1, 32'h0080_0000, 1);          // LB
    run_op(0, 4, 32'h102, 32'h0, 5'd8, 1, 2, 32'h0080_0000, 0);          // LBU
    run_op(0, 1, 32'h102, 32'h0, 5'd9, 0, 1, 32'h8001_0000, 2);          // LH, min latency
    run_op(0, 2, 32'h100, 32'h0, 5'd3, 20, 1, 32'h1234_5678, 2);         // gnt withheld -> timeout
    run_op(1, 2, 32'h200, 32'h55AA_1234, 5'd4, 3, 1, 32'h0, 1);          // gnt on last cycle -> timeout
    run_op(0, 2, 32'h300, 32'h0, 5'd6, 2, 1, 32'hCAFE_F00D, 0);          // just within limit
    run_op(0, 2, 32'h101, 32'h0, 5'd10, 0, 1, 32'hDEAD_BEEF, 0);         // misaligned LW
    run_op(1, 1, 32'h0F3, 32'h0000_BEEF, 5'd11, 0, 1, 32'h0, 0);         // misaligned SH
    run_op(0, 3, 32'h400, 32'h0, 5'd12, 0, 1, 32'h1, 0);                 // illegal load funct3
    run_op(1, 3, 32'h400, 32'h1, 5'd13, 0, 1, 32'h1, 1);                 // illegal store funct3

    // Reset while waiting for the response; the late response must vanish.
    chk_en = 1'b0;
    in_valid = 1'b1; in_is_store = 1'b0; in_funct3 = 3'd2; in_addr = 32'h500; in_rd = 5'd1;
    @(posedge clk); #1;
    in_valid = 1'b0; mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_req", 32'(mem_req), 32'h0);
    chk("midrst_out_valid", 32'(out_valid), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    chk("midrst_in_ready", 32'(in_ready), 32'h1);
    chk("midrst_no_valid", 32'(out_valid), 32'h0);
    chk("midrst_out_data", out_data, 32'h0);
    chk("midrst_mem_req2", 32'(mem_req), 32'h0);
    @(posedge clk); #1;
    chk("midrst_still_idle", 32'(out_valid), 32'h0);
    exp_rdy = 1'b1; exp_vld = 1'b0; exp_req = 1'b0;
    chk_en  = 1'b1;

    // Randomized traffic.
    for (int n = 0; n < 250; n++) begin
      st = 1'($urandom);
      if ($urandom % 8 == 0) f3 = int'($urandom % 8);
      else if (st) f3 = int'($urandom % 3);
      else f3 = legal_ld[$urandom % 5];
      run_op(st, f3, $urandom, $urandom, 5'($urandom), int'($urandom % 4),
             1 + int'($urandom % 3), $urandom, int'($urandom % 3));
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
